// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module : load_store_unit_pkg
// Desc   : Shared size encodings, FSM state type and alignment helper for the LSU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

   typedef logic [1:0] lsu_size_t;
   localparam lsu_size_t SZ_B = 2'b00;
   localparam lsu_size_t SZ_H = 2'b01;
   localparam lsu_size_t SZ_W = 2'b10;

   typedef logic [1:0] lsu_state_t;
   localparam lsu_state_t ST_IDLE   = 2'd0;
   localparam lsu_state_t ST_ACCESS = 2'd1;
   localparam lsu_state_t ST_RESP   = 2'd2;

   // Size 2'b11 is treated as a word, so it falls into the default arm.
   function automatic logic lsu_misaligned(input lsu_size_t size, input logic [1:0] off);
      logic mis;
      case (size)
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module : lsu_lane_align
// Desc   : Combinational byte-lane logic: store strobes/replication, load extract.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [1:0]  off_al;
   logic [31:0] shifted;

   // Offsets are forced down to the access size so misaligned requests stay in-word.
   always_comb begin
      off_al  = 2'b00;
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      case (size_i)
         SZ_B: begin
            off_al  = off_i;
            be_o    = 4'b0001 << off_al;
            wdata_o = {4{wdata_i[7:0]}};
         end
         SZ_H: begin
            off_al  = {off_i[1], 1'b0};
            be_o    = 4'b0011 << off_al;
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: begin
            off_al  = 2'b00;
            be_o    = 4'b1111;
            wdata_o = wdata_i;
         end
      endcase
   end

   always_comb begin
      shifted = rdata_i >> {off_al, 3'b000};
      case (size_i)
         SZ_B:    rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
         SZ_H:    rdata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
         default: rdata_o = shifted;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Desc   : Single-outstanding load/store unit with access timeout.
//          Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [3:0]        lane_be;
   logic [31:0]       lane_wdata;
   logic [31:0]       lane_rdata;
   logic              trap;
   logic              in_access;
   logic              in_resp;

   lsu_lane_align u_lane (
      .size_i     (size_q),
      .off_i      (addr_q[1:0]),
      .unsigned_i (uns_q),
      .wdata_i    (wdata_q),
      .rdata_i    (mem_rdata),
      .be_o       (lane_be),
      .wdata_o    (lane_wdata),
      .rdata_o    (lane_rdata)
   );

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = lsu_misaligned(req_size, req_addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = '0;
               rdata_d = 32'h0;
               err_d   = trap;
               state_d = trap ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // An ack landing on the final allowed cycle still wins over the timeout.
            if (mem_ack) begin
               rdata_d = we_q ? 32'h0 : lane_rdata;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = 32'h0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign in_access = (state_q == ST_ACCESS);
   assign in_resp   = (state_q == ST_RESP);

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = in_resp;
   assign rsp_err   = in_resp & err_q;
   assign rsp_rdata = in_resp ? rdata_q : 32'h0;

   assign mem_en    = in_access;
   assign mem_be    = (in_access && we_q) ? lane_be : 4'b0000;
   assign mem_addr  = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign mem_wdata = in_access ? lane_wdata : 32'h0;

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, byte-address width.
REQ-002 SHALL have parameter: TIMEOUT, 15, maximum ACCESS cycles without mem_ack.
REQ-003 SHALL have port: clk  in  1  clock; all state changes on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port: req_valid  in  1  core request present.
REQ-006 SHALL have port: req_ready  out  1  unit accepts request this cycle.
REQ-007 SHALL have port: req_we  in  1  1=store, 0=load.
REQ-008 SHALL have port: req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-009 SHALL have port: req_unsigned  in  1  zero-extend load (lbu/lhu).
REQ-010 SHALL have port: req_addr  in  ADDR_W  byte address.
REQ-011 SHALL have port: req_wdata  in  32  store data, right-aligned.
REQ-012 SHALL have port: rsp_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port: rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port: rsp_err  out  1  misalignment or timeout; valid with rsp_valid.
REQ-015 SHALL have port: mem_en  out  1  memory access active.
REQ-016 SHALL have port: mem_be  out  4  byte-write strobes; 0000 on loads.
REQ-017 SHALL have port: mem_addr  out  ADDR_W  word address (byte address with [1:0]=00).
REQ-018 SHALL have port: mem_wdata  out  32  lane-replicated store data.
REQ-019 SHALL have port: mem_rdata  in  32  full word read.
REQ-020 SHALL have port: mem_ack  in  1  access complete; mem_rdata valid same cycle.

Function
REQ-021 SHALL implement FSM IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-022 IDLE: on req_valid SHALL register all req_* fields and go to ACCESS, or to RESP with rsp_err=1 if misaligned (see REQ-033).
REQ-023 ACCESS: SHALL hold mem_en=1 and stable mem_addr/mem_be/mem_wdata until mem_ack or timeout.
REQ-024 ACCESS: on mem_ack SHALL latch extended load data and go to RESP; mem_en drops the next cycle.
REQ-025 ACCESS: SHALL count cycles; when TIMEOUT cycles elapse without mem_ack, SHALL go to RESP with rsp_err=1, rsp_rdata=0.
REQ-026 RESP: SHALL assert rsp_valid for exactly one cycle, then return to IDLE; minimum request-to-rsp_valid latency is 2 cycles (mem_ack in first ACCESS cycle).
REQ-027 Store strobes SHALL be byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111.
REQ-028 Store data SHALL be byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-029 Load extraction SHALL shift mem_rdata right by 8*addr[1:0], then sign- or zero-extend per req_size/req_unsigned.
REQ-030 mem_ack outside ACCESS SHALL be ignored; req_valid outside IDLE SHALL be ignored.

Reset
REQ-031 rst SHALL force IDLE, clear timeout counter and captured fields, and drive req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_en=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-032 rst during ACCESS SHALL abort the access with no rsp_valid pulse.

Configuration
REQ-033 With LSU_MISALIGN_TRAP_EN defined, half with addr[0]=1 or word with addr[1:0]!=00 SHALL skip ACCESS and respond rsp_err=1 in 1 cycle, with no mem_en.
REQ-034 Without LSU_MISALIGN_TRAP_EN, misaligned accesses SHALL proceed with offset low bits cleared to size alignment, rsp_err only on timeout.

Structure
REQ-035 Shared package SHALL hold size encodings (SZ_B/SZ_H/SZ_W) and the FSM state typedef.
REQ-036 Lane logic SHALL be one sub-module lsu_lane_align (strobes, store replication, load extraction), purely combinational.

Verification
REQ-037 sb addr 0x13 data 0xAB, ack after 1 cycle -> mem_be 1000, mem_wdata 0xABABABAB, mem_addr 0x10, rsp_err 0.
REQ-038 lb addr 0x21, mem_rdata 0x0000_8000 -> rsp_rdata 0xFFFF_FF80; lbu same -> 0x0000_0080.
REQ-039 lh addr 0x22, mem_rdata 0x8001_0000 -> rsp_rdata 0xFFFF_8001; mem_be 0000.
REQ-040 lw addr 0x40, mem_ack never -> rsp_valid with rsp_err 1 after 15 ACCESS cycles, rsp_rdata 0.
REQ-041 sw addr 0x42 with macro -> rsp_err 1 one cycle after accept, mem_en never high; without macro -> mem_addr 0x40, mem_be 1111.
REQ-042 rst asserted in ACCESS -> next cycle IDLE, mem_en 0, req_ready 1, no rsp_valid.
